divn_seq: RTL and testbench

- Iterative unsigned n-bit divider. It is the inverse operation of the team's combinational n-bit shift-add multiplier.
- Uses restoring division and retires one quotient bit per clock.
- Has a start/busy/done handshake so arithmetic datapaths can share one divider without a wide combinational array.
- Check identity: dividend = quotient*divisor + remainder, which lets the existing multiplier serve as a reference model.

---
 rtl/divn_seq.sv | 102 ++++++++++
 tb/tb_divn_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/divn_seq.sv
// Iterative restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// A zero divisor completes in a single cycle with an all-ones quotient and div_by_zero set.
module divn_seq #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int cw = $clog2(n);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [n-1:0]   q, d;
  logic [n:0]     r;
  logic [cw-1:0]  cnt;

  logic           accept;
  logic [n:0]     shifted, t, r_step;
  logic [n-1:0]   q_step;

  // Extra remainder bit keeps the borrow of the trial subtraction at max operands.
  always_comb begin
    shifted = {r[n-1:0], q[n-1]};
    t       = shifted - {1'b0, d};
    if (!t[n]) begin
      r_step = t;
      q_step = {q[n-2:0], 1'b1};
    end else begin
      r_step = shifted;
      q_step = {q[n-2:0], 1'b0};
    end
  end

  assign accept = start && (state != RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == '0) state_nxt = DONE;
      DONE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && divisor != '0) begin
      q   <= dividend;
      r   <= '0;
      d   <= divisor;
      cnt <= cw'(n - 1);
    end else if (accept) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (state == RUN) begin
      q   <= q_step;
      r   <= r_step;
      cnt <= cnt - cw'(1);
      // Results are published only at the edge that raises done.
      if (cnt == '0) begin
        quotient    <= q_step;
        remainder   <= r_step[n-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divn_seq.sv
// Directed and randomized checks of divn_seq at n=4 and n=8.
// Latency is counted in rising edges after the edge that accepted start.
module tb_divn_seq;

  logic clk = 1'b0;
  logic rst;

  logic       start4, busy4, done4, dz4;
  logic [3:0] dividend4, divisor4, quotient4, remainder4;

  logic       start8, busy8, done8, dz8;
  logic [7:0] dividend8, divisor8, quotient8, remainder8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  divn_seq #(.n(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(dividend4), .divisor(divisor4),
    .busy(busy4), .done(done4), .quotient(quotient4), .remainder(remainder4),
    .div_by_zero(dz4)
  );

  divn_seq #(.n(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dz8)
  );

  typedef struct {
    logic [3:0] a, b, q, r;
    logic       dz;
    int         lat;
    int         busy_cycles;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  task automatic div4(input logic [3:0] a, input logic [3:0] b, output int lat, output int bc);
    start4 = 1'b1; dividend4 = a; divisor4 = b;
    lat = 0; bc = 0;
    @(negedge clk);
    start4 = 1'b0;
    while (!done4 && lat < 40) begin
      if (busy4) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic div8(input logic [7:0] a, input logic [7:0] b, output int lat);
    start8 = 1'b1; dividend8 = a; divisor8 = b;
    lat = 0;
    @(negedge clk);
    start8 = 1'b0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[7];
    int   lat, bc, ndone;
    logic [3:0] cap_q, cap_r;
    int   a, b;

    // Divide by zero finishes at the accepting edge itself, hence lat 0 and no busy.
    vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0, lat: 4, busy_cycles: 4};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0, lat: 4, busy_cycles: 4};
    vecs[2] = '{a: 4'd5,  b: 4'd7,  q: 4'd0,  r: 4'd5, dz: 1'b0, lat: 4, busy_cycles: 4};
    vecs[3] = '{a: 4'd0,  b: 4'd9,  q: 4'd0,  r: 4'd0, dz: 1'b0, lat: 4, busy_cycles: 4};
    vecs[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0, lat: 4, busy_cycles: 4};
    vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, dz: 1'b1, lat: 0, busy_cycles: 0};
    vecs[6] = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0, dz: 1'b0, lat: 4, busy_cycles: 4};

    rst = 1'b1;
    start4 = 1'b0; dividend4 = '0; divisor4 = '0;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_q4", quotient4, 0);
    check("rst_r4", remainder4, 0);
    check("rst_dz4", dz4, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      div4(vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i), bc, vecs[i].busy_cycles);
      check($sformatf("v%0d_q", i), quotient4, vecs[i].q);
      check($sformatf("v%0d_r", i), remainder4, vecs[i].r);
      check($sformatf("v%0d_dz", i), dz4, vecs[i].dz);
      @(negedge clk);
      check($sformatf("v%0d_done_drop", i), done4, 0);
    end

    // A start pulse during RUN must not restart or re-sample the operands.
    start4 = 1'b1; dividend4 = 4'd14; divisor4 = 4'd4;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; dividend4 = 4'd3; divisor4 = 4'd1;
    @(negedge clk);
    start4 = 1'b0;
    ndone = 0; cap_q = '0; cap_r = '0;
    repeat (12) begin
      @(negedge clk);
      if (done4) begin
        ndone++;
        cap_q = quotient4;
        cap_r = remainder4;
      end
    end
    check("ign_ndone", ndone, 1);
    check("ign_q", cap_q, 3);
    check("ign_r", cap_r, 2);

    // Reset two cycles into a division aborts it and clears the held results.
    start4 = 1'b1; dividend4 = 4'd12; divisor4 = 4'd5;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy4, 0);
    check("abort_done", done4, 0);
    check("abort_q", quotient4, 0);
    check("abort_r", remainder4, 0);
    check("abort_dz", dz4, 0);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // Back-to-back at n=8: the second start is presented during the done cycle.
    div8(8'd255, 8'd16, lat);
    check("n8_lat1", lat, 8);
    check("n8_q1", quotient8, 15);
    check("n8_r1", remainder8, 15);
    div8(8'd200, 8'd7, lat);
    check("n8_lat2", lat, 8);
    check("n8_q2", quotient8, 28);
    check("n8_r2", remainder8, 4);
    check("n8_dz2", dz8, 0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(1, 255);
      div8(a[7:0], b[7:0], lat);
      check($sformatf("rnd%0d_q %0d/%0d", i, a, b), quotient8, a / b);
      check($sformatf("rnd%0d_ident %0d/%0d", i, a, b),
            (quotient8 * b + remainder8 == a) && (remainder8 < b), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
